// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall counter: counts strobed cycles without a slave response while a master
// is granted and flags the cycle on which the limit is reached.
module wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic err_i,
  output logic timeout_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Only meaningful while a grant is held; a stale count in IDLE must not fire.
  assign timeout_c = busy_i && (count_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    count_d = count_q;
    if (!busy_i || ack_i || err_i || timeout_c) begin
      count_d = '0;
    end else if (stb_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter onto a single shared slave bus.
// Optional stall abort enabled with macro WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      ACLK,
  input  logic                      ARESET,

  input  logic [ADDR_WIDTH-1:0]     m0_adr_i,
  input  logic [DATA_WIDTH-1:0]     m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
  input  logic                      m0_we_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_cyc_i,
  output logic [DATA_WIDTH-1:0]     m0_dat_o,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,

  input  logic [ADDR_WIDTH-1:0]     m1_adr_i,
  input  logic [DATA_WIDTH-1:0]     m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
  input  logic                      m1_we_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_cyc_i,
  output logic [DATA_WIDTH-1:0]     m1_dat_o,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,

  output logic [ADDR_WIDTH-1:0]     s_adr_o,
  output logic [DATA_WIDTH-1:0]     s_dat_o,
  output logic [DATA_WIDTH/8-1:0]   s_sel_o,
  output logic                      s_we_o,
  output logic                      s_stb_o,
  output logic                      s_cyc_o,
  input  logic [DATA_WIDTH-1:0]     s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,

  output logic [NUM_MASTERS-1:0]    gnt_o,
  output logic                      timeout_o
);

  state_t state_q;
  state_t state_d;
  logic   last_grant_q;
  logic   last_grant_d;

  logic   gnt0;
  logic   gnt1;
  logic   busy;
  logic   grant_stb;
  logic   grant_cyc;
  logic   timeout_hit;

  assign gnt0 = (state_q == GRANT0);
  assign gnt1 = (state_q == GRANT1);
  assign busy = gnt0 | gnt1;

  assign grant_cyc = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
  assign grant_stb = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (ACLK),
    .rst       (ARESET),
    .busy_i    (busy),
    .stb_i     (grant_stb),
    .ack_i     (s_ack_i),
    .err_i     (s_err_i),
    .timeout_c (timeout_hit)
  );
`else
  logic unused_timeout_cfg;

  // No stall abort: a silent slave holds the grant indefinitely.
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state: ties go to the master not recorded in last_grant; single
  // requests are granted without touching the round-robin pointer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_grant_q) begin
            state_d      = GRANT0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = GRANT1;
            last_grant_d = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = GRANT0;
        end else if (m1_cyc_i) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (!m0_cyc_i || timeout_hit) begin
          state_d = IDLE;
        end
      end
      GRANT1: begin
        if (!m1_cyc_i || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Slave mux: master 0 values park on the bus while idle, controls held low.
  always_comb begin
    s_adr_o   = gnt1 ? m1_adr_i : m0_adr_i;
    s_dat_o   = gnt1 ? m1_dat_i : m0_dat_i;
    s_sel_o   = gnt1 ? m1_sel_i : m0_sel_i;
    s_we_o    = (gnt0 & m0_we_i) | (gnt1 & m1_we_i);
    s_cyc_o   = grant_cyc & ~timeout_hit;
    s_stb_o   = grant_stb & ~timeout_hit;

    m0_dat_o  = s_dat_i;
    m1_dat_o  = s_dat_i;
    m0_ack_o  = gnt0 & s_ack_i & ~timeout_hit;
    m1_ack_o  = gnt1 & s_ack_i & ~timeout_hit;
    m0_err_o  = gnt0 & (s_err_i | timeout_hit);
    m1_err_o  = gnt1 & (s_err_i | timeout_hit);

    gnt_o     = {gnt1, gnt0};
    timeout_o = timeout_hit;
  end

endmodule
